// File: rtl/clk_gen_pkg.sv
// Shared types and the phase clamp for the clock-enable generator.
package clk_gen_pkg;
   localparam int DIV_W_DEF = 4;
   localparam int DIV_W_MAX = 16;

   typedef logic [DIV_W_MAX-1:0] cfg_field_t;

   typedef struct packed {
      cfg_field_t div;
      cfg_field_t phase;
   } chan_cfg_t;

   // Strobe phase actually used: the programmed phase, clamped into the counter range.
   function automatic cfg_field_t eff_phase(input chan_cfg_t cfg);
      cfg_field_t last;
      last = cfg.div - cfg_field_t'(1);
      if (cfg.div == '0)
         return '0;
      else if (cfg.phase > last)
         return last;
      else
         return cfg.phase;
   endfunction
endpackage

// File: rtl/clk_enable_chan.sv
// One channel: divide counter, phase strobe, square-wave toggle and config apply; outputs registered.
// apply_ok marks edges where a pending config may land (wrap edge or halted channel).
module clk_enable_chan
   import clk_gen_pkg::*;
#(
   parameter int               DIV_W       = DIV_W_DEF,
   parameter logic [DIV_W-1:0] RESET_DIV   = '0,
   parameter logic [DIV_W-1:0] RESET_PHASE = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             sync,
   input  logic             apply,
   input  logic [DIV_W-1:0] apply_div,
   input  logic [DIV_W-1:0] apply_phase,
   output logic             apply_ok,
   output logic             ch_en,
   output logic             ch_clk
);
   // Parking the counter on its last value makes the release edge a wrap, so cycle 0 starts at cnt=0.
   localparam logic [DIV_W-1:0] RESET_CNT = (RESET_DIV == '0) ? '0 : RESET_DIV - DIV_W'(1);

   logic [DIV_W-1:0] div_q, phase_q, cnt_q;
   logic [DIV_W-1:0] new_div, new_phase, cnt_inc, cur_eff, new_eff;
   logic             wrap, halted;
   chan_cfg_t        cur_cfg, new_cfg;

   always_comb begin
      halted    = (div_q == '0);
      wrap      = (cnt_q == div_q - DIV_W'(1));
      apply_ok  = halted || wrap;
      cnt_inc   = wrap ? '0 : cnt_q + DIV_W'(1);
      new_div   = apply ? apply_div : div_q;
      new_phase = apply ? apply_phase : phase_q;
      cur_cfg   = '{div: cfg_field_t'(div_q), phase: cfg_field_t'(phase_q)};
      new_cfg   = '{div: cfg_field_t'(new_div), phase: cfg_field_t'(new_phase)};
      cur_eff   = DIV_W'(eff_phase(cur_cfg));
      new_eff   = DIV_W'(eff_phase(new_cfg));
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         div_q   <= RESET_DIV;
         phase_q <= RESET_PHASE;
         cnt_q   <= RESET_CNT;
         ch_en   <= 1'b0;
         ch_clk  <= 1'b0;
      end else begin
         div_q   <= new_div;
         phase_q <= new_phase;
         if (sync || apply) begin
            // Realign/reload: strobe follows the new phase, square wave only reset by sync.
            cnt_q <= '0;
            ch_en <= (new_div != '0) && (new_eff == '0);
            if (sync)
               ch_clk <= 1'b0;
         end else if (halted) begin
            cnt_q <= '0;
            ch_en <= 1'b0;
         end else begin
            cnt_q  <= cnt_inc;
            ch_en  <= (cnt_inc == cur_eff);
            ch_clk <= ch_clk ^ ch_en;
         end
      end
   end
endmodule

// File: rtl/clk_enable_gen.sv
// NUM_CH programmable enable strobes and phase clocks on one clock; all outputs registered.
// Single pending config slot: cfg_ready low from accept until the target channel applies it.
module clk_enable_gen
   import clk_gen_pkg::*;
#(
   parameter int                      NUM_CH      = 4,
   parameter int                      DIV_W       = DIV_W_DEF,
   parameter logic [NUM_CH*DIV_W-1:0] RESET_DIV   = {4'd2, 4'd1, 4'd1, 4'd0},
   parameter logic [NUM_CH*DIV_W-1:0] RESET_PHASE = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              sync,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [3:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] ch_clk
);
   logic [3:0]        pend_ch;
   logic [DIV_W-1:0]  pend_div, pend_phase;
   logic [NUM_CH-1:0] apply, apply_ok;
   logic              accept, ch_ok;

   assign accept = cfg_valid && cfg_ready;
   assign ch_ok  = ({1'b0, cfg_ch} < 5'(NUM_CH));

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // cfg_ready low means the slot holds a request.
      assign apply[i] = !cfg_ready && (pend_ch == 4'(i)) && apply_ok[i];

      clk_enable_chan #(
         .DIV_W       (DIV_W),
         .RESET_DIV   (RESET_DIV[i*DIV_W +: DIV_W]),
         .RESET_PHASE (RESET_PHASE[i*DIV_W +: DIV_W])
      ) u_chan (
         .clock       (clock),
         .reset       (reset),
         .sync        (sync),
         .apply       (apply[i]),
         .apply_div   (pend_div),
         .apply_phase (pend_phase),
         .apply_ok    (apply_ok[i]),
         .ch_en       (ch_en[i]),
         .ch_clk      (ch_clk[i])
      );
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cfg_ready  <= 1'b1;
         cfg_done   <= 1'b0;
         cfg_err    <= 1'b0;
         pend_ch    <= '0;
         pend_div   <= '0;
         pend_phase <= '0;
      end else begin
         cfg_done <= |apply;
         cfg_err  <= accept && !ch_ok;
         // accept needs an empty slot and apply needs a full one, so they never coincide.
         if (|apply) begin
            cfg_ready <= 1'b1;
         end else if (accept && ch_ok) begin
            cfg_ready  <= 1'b0;
            pend_ch    <= cfg_ch;
            pend_div   <= cfg_div;
            pend_phase <= cfg_phase;
         end
      end
   end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: a cycle-by-cycle vector table plus a held-valid handshake sequence.
module tb_clk_enable_gen;
   localparam int NUM_CH = 4;
   localparam int DIV_W  = 4;

   logic              clock     = 1'b0;
   logic              reset     = 1'b0;
   logic              sync      = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [3:0]        cfg_ch    = '0;
   logic [DIV_W-1:0]  cfg_div   = '0;
   logic [DIV_W-1:0]  cfg_phase = '0;
   logic              cfg_ready, cfg_done, cfg_err;
   logic [NUM_CH-1:0] ch_en, ch_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int lat;

   always #5 clock = ~clock;

   clk_enable_gen #(
      .NUM_CH      (NUM_CH),
      .DIV_W       (DIV_W),
      .RESET_DIV   ({4'd2, 4'd1, 4'd1, 4'd0}),
      .RESET_PHASE (16'h0000)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_phase (cfg_phase),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .ch_en     (ch_en),
      .ch_clk    (ch_clk)
   );

   // Inputs are what the bench drives during the cycle; expectations are the outputs seen in that cycle.
   typedef struct {
      logic       rst;
      logic       snc;
      logic       cv;
      logic [3:0] ch;
      logic [3:0] dv;
      logic [3:0] ph;
      logic [3:0] en;
      logic [3:0] ck;
      logic       rdy;
      logic       dn;
      logic       er;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic snc, input logic cv, input logic [3:0] ch,
                      input logic [3:0] dv, input logic [3:0] ph, input logic [3:0] en,
                      input logic [3:0] ck, input logic rdy, input logic dn, input logic er);
      vec_t v;
      v = '{rst: rst, snc: snc, cv: cv, ch: ch, dv: dv, ph: ph, en: en, ck: ck, rdy: rdy, dn: dn, er: er};
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      //   rst   snc   cv    ch     dv     ph     en       ck       rdy   dn    er
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0); // last reset cycle
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0); // cycle 0
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'b1110, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b1000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd1, 4'd4, 4'd2, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0); // ch1 D=4 P=2
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'b1110, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1100, 4'b1010, 1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd2, 4'd3, 4'd7, 4'b0100, 4'b0110, 1'b1, 1'b0, 1'b0); // ch2 D=3 P=7
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b0010, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0); // ch2 halt
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1010, 4'b0100, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b1110, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1100, 4'b1110, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 4'b0000, 4'b0110, 1'b1, 1'b1, 1'b0); // ch2 D=1
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1010, 4'b0110, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b1100, 1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd5, 4'd7, 4'd3, 4'b1100, 4'b1000, 1'b1, 1'b0, 1'b0); // bad channel
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 4'd1, 4'b0100, 4'b1110, 1'b1, 1'b0, 1'b0); // ch3 D=3 P=1
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1100, 4'b1010, 1'b0, 1'b0, 1'b0);
      add(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b0110, 1'b0, 1'b0, 1'b0); // sync + apply
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1100, 4'b0100, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b1, 4'd1, 4'd5, 4'd0, 4'b0110, 4'b1000, 1'b1, 1'b0, 1'b0); // ch1 D=5
      add(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0100, 4'b1110, 1'b0, 1'b0, 1'b0); // reset, pending
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'b1110, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b1000, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b0110, 4'b0110, 1'b1, 1'b0, 1'b0);
      add(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'b1110, 4'b0000, 1'b1, 1'b0, 1'b0);

      reset = 1'b0;
      step();
      step();
      foreach (vecs[k]) begin
         chk($sformatf("v%0d.ch_en", k), 32'(ch_en), 32'(vecs[k].en));
         chk($sformatf("v%0d.ch_clk", k), 32'(ch_clk), 32'(vecs[k].ck));
         chk($sformatf("v%0d.cfg_ready", k), 32'(cfg_ready), 32'(vecs[k].rdy));
         chk($sformatf("v%0d.cfg_done", k), 32'(cfg_done), 32'(vecs[k].dn));
         chk($sformatf("v%0d.cfg_err", k), 32'(cfg_err), 32'(vecs[k].er));
         reset     = vecs[k].rst;
         sync      = vecs[k].snc;
         cfg_valid = vecs[k].cv;
         cfg_ch    = vecs[k].ch;
         cfg_div   = vecs[k].dv;
         cfg_phase = vecs[k].ph;
         step();
      end

      // Held-valid handshake: second request only lands in the cfg_done cycle.
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      cfg_valid = 1'b1;
      cfg_ch    = 4'd3;
      cfg_div   = 4'd3;
      cfg_phase = 4'd0;
      chk("hs.c0.ready", 32'(cfg_ready), 32'd1);
      step();
      chk("hs.c1.ready", 32'(cfg_ready), 32'd0);
      cfg_ch    = 4'd1;
      cfg_div   = 4'd2;
      cfg_phase = 4'd1;
      lat = 0;
      while (!cfg_done && lat < 8) begin
         step();
         lat++;
      end
      chk("hs.done_latency", 32'(lat), 32'd1);
      chk("hs.c2.ready", 32'(cfg_ready), 32'd1);
      chk("hs.c2.en3", 32'(ch_en[3]), 32'd1);
      step();
      cfg_valid = 1'b0;
      chk("hs.c3.ready", 32'(cfg_ready), 32'd0);
      chk("hs.c3.done", 32'(cfg_done), 32'd0);
      chk("hs.c3.en3", 32'(ch_en[3]), 32'd0);
      step();
      chk("hs.c4.done", 32'(cfg_done), 32'd1);
      chk("hs.c4.ready", 32'(cfg_ready), 32'd1);
      chk("hs.c4.en", 32'(ch_en), 32'b0100);
      step();
      chk("hs.c5.done", 32'(cfg_done), 32'd0);
      chk("hs.c5.en", 32'(ch_en), 32'b1110);
      step();
      chk("hs.c6.en", 32'(ch_en), 32'b0100);
      step();
      chk("hs.c7.en", 32'(ch_en), 32'b0110);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
